// File: rtl/axis_rx_pkg.sv
// Shared types and helpers for the AXI4-Stream packet RX buffer.
// Holds the FSM state encoding and the tkeep popcount / lane-offset helpers.
package axis_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Widest supported beat (256-bit data) has 32 byte lanes.
    localparam int MAX_LANES = 32;

    // Number of set bits in a (zero-extended) tkeep vector.
    function automatic int unsigned popcount(
        input logic [MAX_LANES-1:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Compacted position of a lane: kept lanes strictly below it.
    function automatic int unsigned lane_offset(
        input logic [MAX_LANES-1:0] v,
        input int unsigned          lane
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lane && v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/pkt_byte_ram.sv
// Byte buffer built from KEEP_W interleaved banks (bank = addr mod KEEP_W).
// Ports: aclk/aresetn; i_wr_en, i_wr_base (first byte address), i_wr_cnt
// (bytes in beat), i_wr_data (compacted bytes, byte k at [8k+7:8k]);
// i_rd_addr -> o_rd_data, registered one-cycle read.
module pkt_byte_ram
    import axis_rx_pkg::*;
#(
    parameter int KEEP_W      = 4,
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_W      = 11
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_wr_en,
    input  logic [ADDR_W:0]       i_wr_base,
    input  logic [ADDR_W:0]       i_wr_cnt,
    input  logic [8*KEEP_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [7:0]            o_rd_data
);

    localparam int ROWS   = DEPTH_BYTES / KEEP_W;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BSEL_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

    logic [7:0]        w_q [KEEP_W];
    logic [ROW_W-1:0]  w_rd_row;
    logic [BSEL_W-1:0] w_rd_bank;
    logic [7:0]        r_rd_data;

    assign w_rd_row  = ROW_W'(int'(i_rd_addr) / KEEP_W);
    assign w_rd_bank = BSEL_W'(int'(i_rd_addr) % KEEP_W);

    for (genvar b = 0; b < KEEP_W; b++) begin : g_bank
        logic [7:0]       r_mem [ROWS];
        logic             w_we;
        logic [ROW_W-1:0] w_row;
        logic [7:0]       w_byte;

        // Rotator: bank b takes compacted byte k, where (base + k) maps
        // to bank b. Consecutive addresses never collide within a beat.
        always_comb begin
            int k;
            int a;
            k = (b + KEEP_W - (int'(i_wr_base) % KEEP_W)) % KEEP_W;
            a = int'(i_wr_base) + k;
            w_we   = i_wr_en && (k < int'(i_wr_cnt))
                     && (a < DEPTH_BYTES);
            w_row  = ROW_W'(a / KEEP_W);
            w_byte = i_wr_data[8*k +: 8];
        end

        always_ff @(posedge aclk) begin
            if (w_we) r_mem[w_row] <= w_byte;
        end

        assign w_q[b] = r_mem[w_rd_row];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) r_rd_data <= '0;
        else          r_rd_data <= w_q[w_rd_bank];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_pkt_rx_buffer.sv
// AXI4-Stream packet sink: compacts one frame by tkeep into a byte buffer,
// holds it for random-access reads until released.
// Ports: aclk/aresetn; s_axis_* stream in; pkt_valid/pkt_len/pkt_err frame
// status; pkt_release frees buffer; rd_addr -> rd_data (1-cycle);
// stat_pkts/stat_ovf saturating frame counters.
module axis_pkt_rx_buffer
    import axis_rx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 2048,
    parameter int STAT_W      = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic [DATA_W/8-1:0]           s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic                          pkt_valid,
    output logic [$clog2(DEPTH_BYTES):0]  pkt_len,
    output logic                          pkt_err,
    input  logic                          pkt_release,
    input  logic [$clog2(DEPTH_BYTES)-1:0] rd_addr,
    output logic [7:0]                    rd_data,
    output logic [STAT_W-1:0]             stat_pkts,
    output logic [STAT_W-1:0]             stat_ovf
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int ADDR_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W+1:0] LIM = (ADDR_W+2)'(DEPTH_BYTES);

    state_t              r_state;
    logic                r_tready;
    logic                r_valid;
    logic                r_pkt_err;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_pkt_len;
    logic [STAT_W-1:0]   r_stat_pkts;
    logic [STAT_W-1:0]   r_stat_ovf;

    logic                w_acc;
    logic                w_wr_en;
    logic                w_ovf;
    logic                w_fin_err;
    logic [ADDR_W:0]     w_cnt;
    logic [ADDR_W+1:0]   w_sum;
    logic [ADDR_W:0]     w_len_nxt;
    logic [DATA_W-1:0]   w_cdata;

    assign w_acc   = s_axis_tvalid && r_tready;
    assign w_wr_en = w_acc && (r_state != DROP);
    assign w_cnt   = (ADDR_W+1)'(popcount(MAX_LANES'(s_axis_tkeep)));
    assign w_sum   = {1'b0, r_len} + {1'b0, w_cnt};
    assign w_ovf   = w_sum > LIM;
    assign w_len_nxt = w_ovf ? LIM[ADDR_W:0] : w_sum[ADDR_W:0];
    // In DROP the error is already latched by having entered DROP.
    assign w_fin_err = (r_state == DROP) || w_ovf;

    // Pack kept lanes down to the low bytes, preserving lane order.
    always_comb begin
        w_cdata = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (s_axis_tkeep[i]) begin
                w_cdata[8*lane_offset(MAX_LANES'(s_axis_tkeep), i) +: 8]
                    = s_axis_tdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_tready    <= 1'b0;
            r_valid     <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_len       <= '0;
            r_pkt_len   <= '0;
            r_stat_pkts <= '0;
            r_stat_ovf  <= '0;
        end else begin
            unique case (r_state)
                HOLD: begin
                    if (pkt_release) begin
                        r_state   <= IDLE;
                        r_tready  <= 1'b1;
                        r_valid   <= 1'b0;
                        r_pkt_len <= '0;
                        r_pkt_err <= 1'b0;
                        r_len     <= '0;
                    end
                end
                default: begin
                    r_tready <= 1'b1;
                    if (w_acc) begin
                        if (r_state != DROP) r_len <= w_len_nxt;
                        if (s_axis_tlast) begin
                            r_state   <= HOLD;
                            r_tready  <= 1'b0;
                            r_valid   <= 1'b1;
                            r_pkt_err <= w_fin_err;
                            r_pkt_len <= (r_state == DROP)
                                         ? r_len : w_len_nxt;
                            if (r_stat_pkts != '1)
                                r_stat_pkts <= r_stat_pkts + 1'b1;
                            if (w_fin_err && r_stat_ovf != '1)
                                r_stat_ovf <= r_stat_ovf + 1'b1;
                        end else if (r_state != DROP) begin
                            r_state <= w_ovf ? DROP : RECV;
                        end
                    end
                end
            endcase
        end
    end

    pkt_byte_ram #(
        .KEEP_W      (KEEP_W),
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_wr_en   (w_wr_en),
        .i_wr_base (r_len),
        .i_wr_cnt  (w_cnt),
        .i_wr_data (w_cdata),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign s_axis_tready = r_tready;
    assign pkt_valid     = r_valid;
    assign pkt_len       = r_pkt_len;
    assign pkt_err       = r_pkt_err;
    assign stat_pkts     = r_stat_pkts;
    assign stat_ovf      = r_stat_ovf;

endmodule
